// File: rtl/pipe_reg.sv
// DEPTH-stage, WIDTH-bit register pipeline with per-stage valid bits, a
// valid/ready handshake with bubble collapse, synchronous flush and occupancy count.
module pipe_reg #(
  parameter int unsigned          WIDTH     = 8,
  parameter int unsigned          DEPTH     = 3,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0,
  parameter int unsigned          CW        = $clog2(DEPTH + 1)
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic             i_FLUSH,
  input  logic [WIDTH-1:0] i_D,
  input  logic             i_VALID,
  output logic             o_READY,
  output logic [WIDTH-1:0] o_Q,
  output logic             o_VALID,
  input  logic             i_READY,
  output logic [CW-1:0]    o_COUNT
);

  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("pipe_reg: DEPTH must be at least 1");
    end
  endgenerate

  logic [WIDTH-1:0] d    [DEPTH];
  logic [WIDTH-1:0] up_d [DEPTH];
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] up_v;
  logic [DEPTH-1:0] rdy;
  logic [CW-1:0]    count;
  logic             in_xfer;
  logic             out_xfer;

  // Ready ripples from the output back to the input; an empty stage always accepts.
  always_comb begin
    logic chain;
    chain = i_READY;
    rdy   = '0;
    for (int unsigned j = 0; j < DEPTH; j++) begin
      chain               = !v[DEPTH-1-j] | chain;
      rdy[DEPTH-1-j]      = chain;
    end
  end

  assign o_READY  = rdy[0] & !i_FLUSH & i_RST_N;
  assign in_xfer  = i_VALID & o_READY;
  assign out_xfer = v[DEPTH-1] & i_READY;

  always_comb begin
    up_v[0] = in_xfer;
    up_d[0] = i_D;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      up_v[k] = v[k-1];
      up_d[k] = d[k-1];
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      v     <= '0;
      count <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
    end else if (i_FLUSH) begin
      v     <= '0;
      count <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) d[k] <= RESET_VAL;
    end else begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v[k] <= up_v[k];
          // A bubble moving in leaves the stale data word in place.
          if (up_v[k]) d[k] <= up_d[k];
        end
      end
      count <= count + CW'(in_xfer) - CW'(out_xfer);
    end
  end

  assign o_Q     = d[DEPTH-1];
  assign o_VALID = v[DEPTH-1];
  assign o_COUNT = count;

endmodule
